// File: rtl/regfile_param.sv
`default_nettype none
// ============================================================================
// Module  : regfile_param
// Brief   : DEPTH x WIDTH register file, 2 async read / 2 sync write ports,
//           optional zero register, optional write bypass, busy scoreboard.
// Revision: 1.0
// ============================================================================
module regfile_param #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned ZERO_EN = 1,
    parameter int unsigned BYPASS  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(DEPTH)-1:0] rdAddrA,
    input  logic [$clog2(DEPTH)-1:0] rdAddrB,
    output logic [WIDTH-1:0]         rdDataA,
    output logic [WIDTH-1:0]         rdDataB,
    output logic                     rdReadyA,
    output logic                     rdReadyB,
    input  logic [$clog2(DEPTH)-1:0] wrAddr0,
    input  logic [WIDTH-1:0]         wrData0,
    input  logic                     write0,
    input  logic [$clog2(DEPTH)-1:0] wrAddr1,
    input  logic [WIDTH-1:0]         wrData1,
    input  logic                     write1,
    input  logic [$clog2(DEPTH)-1:0] rsvAddr,
    input  logic                     reserve
);

    localparam int unsigned     AW          = $clog2(DEPTH);
    localparam logic [AW-1:0]   c_ZERO_ADDR = AW'(DEPTH - 1);
    localparam logic            c_ZERO_EN   = (ZERO_EN != 0);
    localparam logic            c_BYPASS    = (BYPASS != 0);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    logic w_wr0_ok;
    logic w_wr1_ok;
    logic w_rsv_ok;

    // Anything aimed at the zero register is dropped before it reaches state.
    assign w_wr0_ok = write0  && !(c_ZERO_EN && (wrAddr0 == c_ZERO_ADDR));
    assign w_wr1_ok = write1  && !(c_ZERO_EN && (wrAddr1 == c_ZERO_ADDR));
    assign w_rsv_ok = reserve && !(c_ZERO_EN && (rsvAddr == c_ZERO_ADDR));

    // Port 1 is applied after port 0 so it wins a same-address collision;
    // reserve is applied last so a new producer wins over a completing write.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (w_wr0_ok) begin
            regs_d[wrAddr0] = wrData0;
            busy_d[wrAddr0] = 1'b0;
        end
        if (w_wr1_ok) begin
            regs_d[wrAddr1] = wrData1;
            busy_d[wrAddr1] = 1'b0;
        end
        if (w_rsv_ok) begin
            busy_d[rsvAddr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rdDataA  = regs_q[rdAddrA];
        rdReadyA = !busy_q[rdAddrA];
        if (c_BYPASS) begin
            if (w_wr0_ok && (wrAddr0 == rdAddrA)) begin
                rdDataA  = wrData0;
                rdReadyA = 1'b1;
            end
            if (w_wr1_ok && (wrAddr1 == rdAddrA)) begin
                rdDataA  = wrData1;
                rdReadyA = 1'b1;
            end
            if (w_rsv_ok && (rsvAddr == rdAddrA)) begin
                rdReadyA = !busy_q[rdAddrA];
            end
        end
        if (c_ZERO_EN && (rdAddrA == c_ZERO_ADDR)) begin
            rdDataA  = '0;
            rdReadyA = 1'b1;
        end
    end

    always_comb begin
        rdDataB  = regs_q[rdAddrB];
        rdReadyB = !busy_q[rdAddrB];
        if (c_BYPASS) begin
            if (w_wr0_ok && (wrAddr0 == rdAddrB)) begin
                rdDataB  = wrData0;
                rdReadyB = 1'b1;
            end
            if (w_wr1_ok && (wrAddr1 == rdAddrB)) begin
                rdDataB  = wrData1;
                rdReadyB = 1'b1;
            end
            if (w_rsv_ok && (rsvAddr == rdAddrB)) begin
                rdReadyB = !busy_q[rdAddrB];
            end
        end
        if (c_ZERO_EN && (rdAddrB == c_ZERO_ADDR)) begin
            rdDataB  = '0;
            rdReadyB = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: doc/regfile_param.md
# regfile_param

Parametrised, multi-ported successor to the 32x64 register file: DEPTH registers of WIDTH bits, two combinational read ports, two synchronous write ports, an optional hard-wired zero register and optional write-to-read bypass. A per-register busy scoreboard lets the issue stage reserve a destination and see when its operands are ready. It sits between decode/issue (read and reserve) and writeback (write), and replaces the fixed-size file in the datapath.

## Interface
- WIDTH, 64, data width in bits (>= 1).
- DEPTH, 32, number of registers; must be a power of two >= 2; AW = log2(DEPTH), derived internally.
- ZERO_EN, 1, when 1, register DEPTH-1 reads as 0, ignores writes and is never busy.
- BYPASS, 1, when 1, a read of an address being written this cycle returns the incoming data.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all registers and busy bits.
- rdAddrA  in  AW  read port A address.
- rdAddrB  in  AW  read port B address.
- rdDataA  out  WIDTH  read port A data, combinational.
- rdDataB  out  WIDTH  read port B data, combinational.
- rdReadyA  out  1  1 when register rdAddrA is not busy.
- rdReadyB  out  1  1 when register rdAddrB is not busy.
- wrAddr0, wrData0, write0  in  AW/WIDTH/1  write port 0 (lower priority).
- wrAddr1, wrData1, write1  in  AW/WIDTH/1  write port 1 (higher priority).
- rsvAddr  in  AW  register to mark busy.
- reserve  in  1  set the busy bit of rsvAddr at the next edge.

## Operation
- Storage: DEPTH x WIDTH flops plus DEPTH busy bits. Reset value: all data 0, all busy 0; hence rdDataA/B = 0 and rdReadyA/B = 1 while reset is held.
- Write: on the rising edge with writeN=1, reg[wrAddrN] <= wrDataN. Both ports may write different addresses in the same cycle. Same address on both ports: port 1 data is stored, port 0 is discarded.
- Zero register (ZERO_EN=1): reads of DEPTH-1 return 0 regardless of writes; writes to it are dropped; reserve of it is dropped; its rdReady is always 1.
- Read: rdDataX = reg[rdAddrX] combinationally. With BYPASS=1 and a live write whose address matches rdAddrX, rdDataX = that write's data (port 1 over port 0); the zero register is never bypassed. With BYPASS=0, the new value appears only after the edge.
- Scoreboard: reserve=1 sets busy[rsvAddr] at the edge. An accepted write (either port) clears busy[wrAddr] at the edge. Reserve and a write to the same address in the same cycle leave busy = 1 (the new producer wins); the data is still written.
- Ready: rdReadyX = !busy[rdAddrX]; with BYPASS=1, a live write to rdAddrX also forces rdReadyX = 1 in that cycle, unless reserve targets the same address in that cycle.
- No arithmetic; address compares are full AW bits, with no wrap or aliasing.

## Timing
- Write latency: 1 edge when BYPASS=0; 0 cycles (same-cycle visibility) when BYPASS=1.
- Reserve-to-not-ready: 1 edge; write-to-ready: 1 edge, or same cycle with BYPASS=1.
- Asynchronous reset takes effect immediately without a clock edge. Writes and reserves in flight at reset assertion are lost. Deassertion is synchronised externally; the first edge after deassertion performs normal writes.
- Read paths are purely combinational, from address/write inputs to rdData/rdReady; no output registers.

## Test plan
- Reset, then write 0xFFFF_FFFF_FFFF_FFFF to r0, 0xAAAA_AAAA_AAAA_AAAA to r1, 0xCCCC to r2, 0xF0F0 to r3 via port 0 -> reads A=r0/B=r1, then A=r2/B=r3 return those values; all ready = 1.
- Both ports write r5 in one cycle (port 0 = 0x1111, port 1 = 0x2222) -> r5 reads 0x2222; different addresses r6/r7 -> both are stored.
- BYPASS=1: write r4 = 0xDEAD with rdAddrA = 4 in the same cycle -> rdDataA = 0xDEAD before the edge. BYPASS=0: rdDataA shows the old value until the edge.
- ZERO_EN=1: write 0x1234 to r31 and reserve r31 -> r31 reads 0 and rdReady = 1; DEPTH=16, WIDTH=8 build passes the first scenario with 8-bit data and r15 as the zero register.
- Reserve r8 -> rdReadyA(r8) = 0 the next cycle; write r8 = 0x55 -> ready = 1 the following cycle (same cycle with bypass); reserve and write r8 together -> busy stays 1 and data = new value.
- Assert reset mid-sequence, between edges, after writes and reserves -> all reads are 0 and all ready = 1 immediately, without a clock edge.
